// File: rtl/cache_ctrl_fsm.sv
// Write-back data-cache controller for the MIPS datapath.
// Hits are served in the same cycle with no stall. A miss stalls the pipeline
// and runs a dirty-victim write-back (when needed), then a line refill over a
// per-word req/ack handshake, then a one-cycle commit. After the commit the
// held instruction is evaluated again, hits and completes.
// The block also keeps saturating miss and write-back counters.
module cache_ctrl_fsm #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WIDX_W          = 2,
  parameter int PERF_W          = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [5:0]        opcode,
  input  logic              hit,
  input  logic              dirty,
  input  logic              mem_ack,
  output logic              stall,
  output logic              cache_we,
  output logic              cache_in_select,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_in_select,
  output logic [WIDX_W-1:0] word_idx,
  output logic [1:0]        size,
  output logic              reg_write_enable,
  output logic              valid_set,
  output logic              dirty_set,
  output logic              dirty_clr,
  output logic [PERF_W-1:0] miss_count,
  output logic [PERF_W-1:0] wb_count
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  // All single-cycle control strobes, grouped so they default to 0 in one go.
  typedef struct packed {
    logic       stall;
    logic       cache_we;
    logic       cache_in_select;
    logic       mem_req;
    logic       mem_we;
    logic       mem_in_select;
    logic       reg_write_enable;
    logic       valid_set;
    logic       dirty_set;
    logic       dirty_clr;
    logic [1:0] size;
  } ctl_t;

  state_t            state_q, state_d;
  logic [WIDX_W-1:0] cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic              miss_inc, wb_inc;
  logic [PERF_W-1:0] miss_q, wb_q;
  ctl_t              ctl;

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB) ||
           (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Low opcode bits select width for both loads and stores: 11 word, 01 half, 00 byte.
  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op[1:0])
      2'b11:   return 2'b10;
      2'b01:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // State, word counter and latched opcode; async reset abandons any transfer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Saturating performance counters: hold at all-ones, never wrap.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      if (miss_inc && (miss_q != '1)) miss_q <= miss_q + 1'b1;
      if (wb_inc && (wb_q != '1))     wb_q   <= wb_q + 1'b1;
    end
  end

  // Next state and strobes. Outputs are gated by reset so that an IDLE hit
  // decode cannot leak out while rst_b is low.
  always_comb begin
    ctl      = '0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    miss_inc = 1'b0;
    wb_inc   = 1'b0;
    if (rst_b) begin
      case (state_q)
        IDLE: begin
          if (is_mem(opcode)) begin
            ctl.size = size_of(opcode);
            if (hit) begin
              if (opcode[3]) begin
                ctl.cache_we        = 1'b1;
                ctl.cache_in_select = 1'b1;
                ctl.dirty_set       = 1'b1;
              end else begin
                ctl.reg_write_enable = 1'b1;
              end
            end else begin
              ctl.stall = 1'b1;
              op_d      = opcode;
              miss_inc  = 1'b1;
              cnt_d     = '0;
              state_d   = dirty ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          ctl.stall         = 1'b1;
          ctl.mem_req       = 1'b1;
          ctl.mem_we        = 1'b1;
          ctl.mem_in_select = 1'b1;
          ctl.size          = size_of(op_q);
          if (mem_ack) begin
            if (cnt_q == LAST_WORD) begin
              cnt_d   = '0;
              wb_inc  = 1'b1;
              state_d = REFILL;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        REFILL: begin
          ctl.stall    = 1'b1;
          ctl.mem_req  = 1'b1;
          ctl.size     = size_of(op_q);
          // Refill data is written only in the cycle memory returns it.
          ctl.cache_we = mem_ack;
          if (mem_ack) begin
            if (cnt_q == LAST_WORD) begin
              cnt_d   = '0;
              state_d = COMMIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          ctl.stall     = 1'b1;
          ctl.valid_set = 1'b1;
          ctl.dirty_clr = 1'b1;
          ctl.size      = size_of(op_q);
          state_d       = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign stall            = ctl.stall;
  assign cache_we         = ctl.cache_we;
  assign cache_in_select  = ctl.cache_in_select;
  assign mem_req          = ctl.mem_req;
  assign mem_we           = ctl.mem_we;
  assign mem_in_select    = ctl.mem_in_select;
  assign reg_write_enable = ctl.reg_write_enable;
  assign valid_set        = ctl.valid_set;
  assign dirty_set        = ctl.dirty_set;
  assign dirty_clr        = ctl.dirty_clr;
  assign size             = ctl.size;
  assign word_idx         = cnt_q;
  assign miss_count       = miss_q;
  assign wb_count         = wb_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm. A second instance with 2-bit counters
// shares the stimulus (own reset) to show counter saturation.
module tb_cache_ctrl_fsm;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] ADD = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_b, rst_s;
  logic [5:0]  opcode;
  logic        hit, dirty, mem_ack;

  logic        stall, cache_we, cache_in_select, mem_req, mem_we, mem_in_select;
  logic [1:0]  word_idx, size;
  logic        reg_write_enable, valid_set, dirty_set, dirty_clr;
  logic [15:0] miss_count, wb_count;

  logic        s_stall, s_cache_we, s_cache_in_select, s_mem_req, s_mem_we, s_mem_in_select;
  logic [1:0]  s_word_idx, s_size;
  logic        s_reg_write_enable, s_valid_set, s_dirty_set, s_dirty_clr;
  logic [1:0]  s_miss_count, s_wb_count;

  logic [11:0] outs;
  assign outs = {stall, cache_we, cache_in_select, mem_req, mem_we, mem_in_select,
                 reg_write_enable, valid_set, dirty_set, dirty_clr, size};

  int n_cmp = 0;
  int n_bad = 0;
  int n_stall;

  cache_ctrl_fsm #(.WORDS_PER_BLOCK(4), .WIDX_W(2), .PERF_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .opcode(opcode), .hit(hit), .dirty(dirty), .mem_ack(mem_ack),
    .stall(stall), .cache_we(cache_we), .cache_in_select(cache_in_select),
    .mem_req(mem_req), .mem_we(mem_we), .mem_in_select(mem_in_select),
    .word_idx(word_idx), .size(size), .reg_write_enable(reg_write_enable),
    .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .miss_count(miss_count), .wb_count(wb_count));

  cache_ctrl_fsm #(.WORDS_PER_BLOCK(4), .WIDX_W(2), .PERF_W(2)) dut_s (
    .clk(clk), .rst_b(rst_s), .opcode(opcode), .hit(hit), .dirty(dirty), .mem_ack(mem_ack),
    .stall(s_stall), .cache_we(s_cache_we), .cache_in_select(s_cache_in_select),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_in_select(s_mem_in_select),
    .word_idx(s_word_idx), .size(s_size), .reg_write_enable(s_reg_write_enable),
    .valid_set(s_valid_set), .dirty_set(s_dirty_set), .dirty_clr(s_dirty_clr),
    .miss_count(s_miss_count), .wb_count(s_wb_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transfer phase of 4 words, acked on the last of every `gap` cycles.
  task automatic phase(input string tag, input bit wb, input int gap, input logic [1:0] exp_size);
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < gap; g++) begin
        mem_ack = (g == gap - 1);
        @(negedge clk);
        if (stall) n_stall++;
        chk($sformatf("%s_w%0d_stall", tag, w), 32'(stall), 32'd1);
        chk($sformatf("%s_w%0d_req", tag, w), 32'(mem_req), 32'd1);
        chk($sformatf("%s_w%0d_mwe", tag, w), 32'(mem_we), 32'(wb));
        chk($sformatf("%s_w%0d_misel", tag, w), 32'(mem_in_select), 32'(wb));
        chk($sformatf("%s_w%0d_widx", tag, w), 32'(word_idx), 32'(w));
        chk($sformatf("%s_w%0d_cwe", tag, w), 32'(cache_we), 32'(!wb && (g == gap - 1)));
        chk($sformatf("%s_w%0d_cisel", tag, w), 32'(cache_in_select), 32'd0);
        chk($sformatf("%s_w%0d_size", tag, w), 32'(size), 32'(exp_size));
        chk($sformatf("%s_w%0d_rwe", tag, w), 32'(reg_write_enable), 32'd0);
        tick();
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic commit(input string tag, input logic [1:0] exp_size);
    @(negedge clk);
    if (stall) n_stall++;
    chk({tag, "_commit_stall"}, 32'(stall), 32'd1);
    chk({tag, "_commit_vs_dc"}, 32'({valid_set, dirty_clr}), 32'h3);
    chk({tag, "_commit_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_commit_size"}, 32'(size), 32'(exp_size));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; rst_s = 1'b0;
    opcode = LW; hit = 1'b1; dirty = 1'b0; mem_ack = 1'b0;
    #12;
    // Reset: all outputs 0 even with an LW hit presented
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_widx", 32'(word_idx), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    chk("rst_wb", 32'(wb_count), 32'd0);
    tick();
    rst_b = 1'b1; rst_s = 1'b1;

    // LW hit: same-cycle register write, word size, no stall
    opcode = LW; hit = 1'b1;
    @(negedge clk);
    chk("lw_hit_rwe", 32'(reg_write_enable), 32'd1);
    chk("lw_hit_stall", 32'(stall), 32'd0);
    chk("lw_hit_size", 32'(size), 32'd2);
    chk("lw_hit_cwe", 32'(cache_we), 32'd0);
    tick();

    // SB hit: store strobes, byte size
    opcode = SB;
    @(negedge clk);
    chk("sb_hit_strobes", 32'({cache_we, cache_in_select, dirty_set}), 32'h7);
    chk("sb_hit_size", 32'(size), 32'd0);
    chk("sb_hit_stall", 32'(stall), 32'd0);
    chk("sb_hit_rwe", 32'(reg_write_enable), 32'd0);
    tick();

    // Non-memory op with miss-looking inputs and a stray ack: nothing happens
    opcode = ADD; hit = 1'b0; dirty = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    chk("nonmem_outs0", 32'(outs), 32'd0);
    tick();
    @(negedge clk);
    chk("nonmem_outs1", 32'(outs), 32'd0);
    chk("nonmem_miss", 32'(miss_count), 32'd0);
    mem_ack = 1'b0;
    tick();

    // LW clean miss, ack every cycle: 5 stall cycles after detect, then hit
    opcode = LW; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    chk("t3_detect_stall", 32'(stall), 32'd1);
    chk("t3_detect_req", 32'(mem_req), 32'd0);
    tick();
    n_stall = 0;
    phase("t3", 1'b0, 1, 2'd2);
    hit = 1'b1;
    commit("t3", 2'd2);
    @(negedge clk);
    chk("t3_rwe", 32'(reg_write_enable), 32'd1);
    chk("t3_stall_after", 32'(stall), 32'd0);
    chk("t3_stall_cycles", 32'(n_stall), 32'd5);
    chk("t3_miss", 32'(miss_count), 32'd1);
    chk("t3_wb", 32'(wb_count), 32'd0);
    tick();

    // SH dirty miss, ack every 3rd cycle
    opcode = SH; hit = 1'b0; dirty = 1'b1;
    @(negedge clk);
    chk("t4_detect_stall", 32'(stall), 32'd1);
    chk("t4_detect_req", 32'(mem_req), 32'd0);
    tick();
    n_stall = 0;
    phase("t4wb", 1'b1, 3, 2'd1);
    chk("t4_wb_count", 32'(wb_count), 32'd1);
    phase("t4rf", 1'b0, 3, 2'd1);
    hit = 1'b1;
    commit("t4", 2'd1);
    @(negedge clk);
    chk("t4_store_strobes", 32'({cache_we, cache_in_select, dirty_set}), 32'h7);
    chk("t4_size", 32'(size), 32'd1);
    chk("t4_stall_after", 32'(stall), 32'd0);
    chk("t4_stall_cycles", 32'(n_stall), 32'd25);
    chk("t4_miss", 32'(miss_count), 32'd2);
    tick();

    // LH clean miss, opcode swapped to a non-memory op during the refill
    opcode = LH; hit = 1'b0; dirty = 1'b0;
    @(negedge clk);
    chk("t5_detect_stall", 32'(stall), 32'd1);
    tick();
    opcode = ADD; hit = 1'b1; dirty = 1'b1;
    n_stall = 0;
    phase("t5", 1'b0, 1, 2'd1);
    commit("t5", 2'd1);
    @(negedge clk);
    chk("t5_idle_outs", 32'(outs), 32'd0);
    chk("t5_miss", 32'(miss_count), 32'd3);
    chk("t5_wb", 32'(wb_count), 32'd1);
    tick();

    // Two more clean misses: 5 total, 2-bit counter holds at 3
    for (int k = 0; k < 2; k++) begin
      opcode = LB; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b1;
      repeat (6) tick();
      opcode = ADD; mem_ack = 1'b0;
    end
    @(negedge clk);
    chk("sat_miss16", 32'(miss_count), 32'd5);
    chk("sat_miss2", 32'(s_miss_count), 32'd3);
    chk("sat_wb2", 32'(s_wb_count), 32'd1);
    chk("sat_idle_outs", 32'(outs), 32'd0);
    tick();

    // Reset asserted mid write-back (word 2)
    opcode = SW; hit = 1'b0; dirty = 1'b1; mem_ack = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t6_pre_widx", 32'(word_idx), 32'd2);
    chk("t6_pre_req", 32'(mem_req), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("t6_rst_outs", 32'(outs), 32'd0);
    chk("t6_rst_widx", 32'(word_idx), 32'd0);
    chk("t6_rst_miss", 32'(miss_count), 32'd0);
    chk("t6_rst_wb", 32'(wb_count), 32'd0);
    tick();
    rst_b = 1'b1;
    opcode = ADD; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("t6_post_outs", 32'(outs), 32'd0);
    chk("t6_post_widx", 32'(word_idx), 32'd0);
    tick();
    opcode = LW; hit = 1'b1;
    @(negedge clk);
    chk("t6_idle_lw_rwe", 32'(reg_write_enable), 32'd1);
    chk("t6_idle_lw_stall", 32'(stall), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
